// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: steps a 1-bit AND/OR/ADD/SLT slice LSB-first over WIDTH cycles.
// Optional zero/ovf flag outputs are enabled by defining ALU_FLAGS_EN.
module alu_serial_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       control,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [3:0]       ctl;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             ai;
    logic             bi;
    logic             sum;
    logic             carry_nxt;
    logic             bit_res;
    logic             last;
    logic             msb_ovf;
    logic [WIDTH-1:0] fin_res;

    assign last = (cnt == CW'(WIDTH - 1));

    // 1-bit slice on the current LSB of the operand shift registers
    always_comb begin
        ai        = a_sr[0] ^ ctl[3];
        bi        = b_sr[0] ^ ctl[2];
        sum       = ai ^ bi ^ carry;
        carry_nxt = (ai & bi) | (ai & carry) | (bi & carry);
        unique case (ctl[1:0])
            2'b00:   bit_res = ai & bi;
            2'b01:   bit_res = ai | bi;
            default: bit_res = sum;
        endcase
    end

    // On the MSB slice, carry is the carry-in to the MSB and carry_nxt the carry-out
    always_comb begin
        msb_ovf = carry ^ carry_nxt;
        if (ctl[1:0] == 2'b11) begin
            fin_res = WIDTH'(sum ^ msb_ovf);
        end else begin
            fin_res = {bit_res, res_sr};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            FIN:     done = 1'b1;
            default: ;
        endcase
    end

    // Operand shifting, carry chain and result capture on entry to FIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            ctl    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
`ifdef ALU_FLAGS_EN
            zero   <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                a_sr  <= a;
                b_sr  <= b;
                ctl   <= control;
                carry <= control[2];
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= (WIDTH-1)'({bit_res, res_sr} >> 1);
                carry  <= carry_nxt;
                cnt    <= cnt + CW'(1);
            end else if (state == FIN) begin
                cnt <= '0;
            end

            if (state == RUN && last) begin
                result <= fin_res;
                cout   <= ctl[1] & carry_nxt;
`ifdef ALU_FLAGS_EN
                zero   <= (fin_res == '0);
                ovf    <= ctl[1] & msb_ovf;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_seq.sv
// Scoreboard bench for alu_serial_seq: directed and random operations against an arithmetic model.
// Flag outputs are connected and checked when ALU_FLAGS_EN is defined.
module tb_alu_serial_seq;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [3:0]   control = '0;
    logic         busy;
    logic         done;
    logic         cout;
    logic [W-1:0] result;
`ifdef ALU_FLAGS_EN
    logic         zero;
    logic         ovf;
`endif

    int checks = 0;
    int failures = 0;
    int done_seen = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         ov;
    } exp_t;

    exp_t sb[$];

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .control (control),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .cout    (cout)
`ifdef ALU_FLAGS_EN
        ,
        .zero    (zero),
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Word-level reference: whole-operand add with carry-in, signed overflow from operand/sum signs
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c);
        exp_t         e;
        logic [W-1:0] ai;
        logic [W-1:0] bi;
        logic [W-1:0] s;
        logic [W:0]   full;
        logic         ov;
        ai   = c[3] ? ~x : x;
        bi   = c[2] ? ~y : y;
        full = {1'b0, ai} + {1'b0, bi} + (W+1)'(c[2]);
        s    = full[W-1:0];
        ov   = (ai[W-1] == bi[W-1]) && (s[W-1] != ai[W-1]);
        case (c[1:0])
            2'b00:   e.res = ai & bi;
            2'b01:   e.res = ai | bi;
            2'b10:   e.res = s;
            default: e.res = W'(s[W-1] ^ ov);
        endcase
        e.co = c[1] ? full[W] : 1'b0;
        e.ov = c[1] ? ov : 1'b0;
        e.z  = (e.res == '0);
        return e;
    endfunction

    // Monitor: every done pulse pops and checks one expected response
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            done_seen++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=%0h required=none", result);
            end else begin
                e = sb.pop_front();
                chk("result", 32'(result), 32'(e.res));
                chk("cout", 32'(cout), 32'(e.co));
`ifdef ALU_FLAGS_EN
                chk("zero", 32'(zero), 32'(e.z));
                chk("ovf", 32'(ovf), 32'(e.ov));
`endif
            end
        end
    end

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [3:0] c, input exp_t e);
        int n;
        sb.push_back(e);
        @(negedge clk);
        a = x;
        b = y;
        control = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        control = 4'($urandom);
        chk("busy_run", 32'(busy), 32'd1);
        n = 1;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(W + 1));
        @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("done_idle", 32'(done), 32'd0);
    endtask

    logic [3:0]   dc [8] = '{4'b0010, 4'b0110, 4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 4'b1100};
    logic [W-1:0] da [8] = '{8'h7F, 8'h05, 8'h33, 8'hFE, 8'h7F, 8'hF0, 8'hF0, 8'hF0};
    logic [W-1:0] db [8] = '{8'h01, 8'h07, 8'h33, 8'h01, 8'h80, 8'h3C, 8'h3C, 8'h3C};
    logic [W-1:0] dr [8] = '{8'h80, 8'hFE, 8'h00, 8'h01, 8'h00, 8'h30, 8'hFC, 8'h03};
    logic         dco[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic         dov[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        exp_t e;
        int   d0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef ALU_FLAGS_EN
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            e.res = dr[i];
            e.co  = dco[i];
            e.z   = (dr[i] == '0);
            e.ov  = dov[i];
            run_op(da[i], db[i], dc[i], e);
        end

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic [3:0]   c;
            x = W'($urandom);
            y = W'($urandom);
            c = 4'($urandom);
            run_op(x, y, c, model(x, y, c));
        end

        // start held high with operands changing every cycle: only every 10th cycle is accepted
        d0 = done_seen;
        for (int k = 0; k < 40; k++) begin
            a = W'($urandom);
            b = W'($urandom);
            control = 4'($urandom);
            start = 1'b1;
            if (k % 10 == 0) sb.push_back(model(a, b, control));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("done_count", 32'(done_seen - d0), 32'd4);

        // Leave a nonzero result, then abort an operation with reset in RUN
        e.res = 8'h03;
        e.co  = 1'b0;
        e.z   = 1'b0;
        e.ov  = 1'b0;
        run_op(8'hF0, 8'h3C, 4'b1100, e);
        @(negedge clk);
        a = 8'hFF;
        b = 8'h01;
        control = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
`ifdef ALU_FLAGS_EN
        chk("abort_zero", 32'(zero), 32'd0);
        chk("abort_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        run_op(8'h7F, 8'h80, 4'b0111, model(8'h7F, 8'h80, 4'b0111));
        run_op(8'hA5, 8'h5A, 4'b0010, model(8'hA5, 8'h5A, 4'b0010));

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
